v_horner_acc: RTL and testbench

// - Sequential, parametrised Vandermonde checksum accumulator over GF(2^W) using Horner's rule.
// - Row i is updated per accepted block as: row_i <- x^i * row_i XOR block.
// - Holds the checksum state internally across a whole message (AD or payload).
// - Exposes valid/ready handshakes on both input and output; replaces the one-cycle combinational update used in the top-level datapath.

---
 rtl/v_horner_acc_pkg.sv | 15 +
 rtl/v_horner_acc_gf_xpow.sv | 18 +
 rtl/v_horner_acc.sv | 114 +++++++++++
 tb/tb_v_horner_acc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_horner_acc_pkg.sv
// Shared field constants and FSM state encoding for the Horner checksum accumulator.
package v_horner_acc_pkg;

    localparam int unsigned FIELD_W    = 64;
    localparam logic [63:0] FIELD_POLY = 64'h1B;
    localparam int unsigned DEF_NROWS  = 4;
    localparam int unsigned DEF_CNTW   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/v_horner_acc_gf_xpow.sv
// Combinational multiply by x^K in GF(2^W); K=0 passes the operand through.
module gf_xpow #(
    parameter int unsigned W    = 64,
    parameter logic [W-1:0] POLY = W'(64'h1B),
    parameter int unsigned K    = 0
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        for (int unsigned k = 0; k < K; k++) begin
            y_o = {y_o[W-2:0], 1'b0} ^ (y_o[W-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/v_horner_acc.sv
// Sequential Vandermonde checksum accumulator: row_i <- x^i * row_i ^ block per accepted block.
module v_horner_acc
    import v_horner_acc_pkg::*;
#(
    parameter int unsigned  W     = FIELD_W,
    parameter int unsigned  NROWS = DEF_NROWS,
    parameter logic [W-1:0] POLY  = W'(FIELD_POLY),
    parameter int unsigned  CNTW  = DEF_CNTW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               full_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_block,
    input  logic               in_last,
    input  logic               fin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NROWS*W-1:0] checksum_out,
    output logic [CNTW-1:0]    blk_cnt,
    output logic               cnt_ovf
);

    state_e                       state_q, state_d;
    logic [NROWS-1:0][W-1:0]      row_q, row_d;
    logic [NROWS-1:0][W-1:0]      xp;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic                         mode_q, mode_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;

    for (genvar g = 0; g < int'(NROWS); g++) begin : g_row
        gf_xpow #(.W(W), .POLY(POLY), .K(g)) u_xpow (
            .a_i (row_q[g]),
            .y_o (xp[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    mode_d  = full_mode;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    // The top row only participates in full (AD) mode.
                    for (int unsigned i = 0; i < NROWS; i++) begin
                        if (i != NROWS - 1 || mode_q) begin
                            row_d[i] = xp[i] ^ in_block;
                        end
                    end
                    if (cnt_q != {CNTW{1'b1}}) begin
                        cnt_d = cnt_q + CNTW'(1);
                        if (cnt_d == {CNTW{1'b1}}) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                if ((in_valid && in_last) || fin) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign checksum_out = row_q;
    assign blk_cnt      = cnt_q;
    assign cnt_ovf      = ovf_q;

endmodule

// File: tb/tb_v_horner_acc.sv
// Directed bench for v_horner_acc with a checksum scoreboard and a small GF(2^64) reference model.
module tb_v_horner_acc;

    logic         clk = 1'b0;
    logic         rst_n, start, full_mode, in_valid, in_last, fin, out_ready;
    logic [63:0]  in_block;
    logic         in_ready, out_valid, cnt_ovf;
    logic [255:0] checksum_out;
    logic [31:0]  blk_cnt;
    logic         s_in_ready, s_out_valid, s_cnt_ovf;
    logic [255:0] s_checksum_out;
    logic [1:0]   s_blk_cnt;

    typedef struct {
        logic [255:0] cs;
        logic [31:0]  cnt;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [63:0] m_row [4];
    bit          m_full;
    int          m_cnt;

    always #5 clk = ~clk;

    v_horner_acc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .full_mode(full_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_last(in_last), .fin(fin), .out_valid(out_valid), .out_ready(out_ready),
        .checksum_out(checksum_out), .blk_cnt(blk_cnt), .cnt_ovf(cnt_ovf)
    );

    v_horner_acc #(.CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .full_mode(full_mode),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_block(in_block),
        .in_last(in_last), .fin(fin), .out_valid(s_out_valid), .out_ready(out_ready),
        .checksum_out(s_checksum_out), .blk_cnt(s_blk_cnt), .cnt_ovf(s_cnt_ovf)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] xt(input logic [63:0] a);
        return {a[62:0], 1'b0} ^ (a[63] ? 64'h1B : 64'h0);
    endfunction

    task automatic m_start(input bit f);
        for (int i = 0; i < 4; i++) m_row[i] = '0;
        m_full = f;
        m_cnt  = 0;
    endtask

    task automatic m_absorb(input logic [63:0] blk);
        logic [63:0] t;
        for (int i = 0; i < 4; i++) begin
            if (i < 3 || m_full) begin
                t = m_row[i];
                for (int k = 0; k < i; k++) t = xt(t);
                m_row[i] = t ^ blk;
            end
        end
        m_cnt++;
    endtask

    task automatic m_push();
        exp_t e;
        e.cs  = {m_row[3], m_row[2], m_row[1], m_row[0]};
        e.cnt = 32'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic push_const(input logic [63:0] r0, r1, r2, r3, input logic [31:0] c);
        exp_t e;
        e.cs  = {r3, r2, r1, r0};
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic mode);
        start     = 1'b1;
        full_mode = mode;
        tick();
        start     = 1'b0;
        full_mode = 1'b0;
    endtask

    task automatic send(input logic [63:0] blk, input logic last, input logic f);
        chk("in_ready_accum", 256'(in_ready), 256'(1));
        in_valid = 1'b1;
        in_block = blk;
        in_last  = last;
        fin      = f;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        fin      = 1'b0;
        in_block = '0;
    endtask

    // Waits (bounded) for out_valid, scores the result, then completes the handshake.
    task automatic collect(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_checksum"}, checksum_out, e.cs);
            chk({tag, "_blk_cnt"}, 256'(blk_cnt), 256'(e.cnt));
        end
        chk({tag, "_in_ready_done"}, 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, 256'(out_valid), 256'(0));
    endtask

    initial begin
        logic [255:0] held;
        logic [63:0]  rb;
        rst_n = 1'b0; start = 1'b0; full_mode = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; fin = 1'b0; out_ready = 1'b0; in_block = '0;
        tick(); tick();
        chk("rst_checksum", checksum_out, 256'(0));
        chk("rst_blk_cnt", 256'(blk_cnt), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_cnt_ovf", 256'(cnt_ovf), 256'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 256'(in_ready), 256'(0));

        // Basic, full mode
        do_start(1'b1);
        push_const(64'h3, 64'h0, 64'h6, 64'hA, 32'd2);
        send(64'd1, 1'b0, 1'b0);
        send(64'd2, 1'b1, 1'b0);
        chk("basic_latency", 256'(out_valid), 256'(1));
        collect("basic");

        // Message mode: top row stays zero
        do_start(1'b0);
        push_const(64'h3, 64'h0, 64'h6, 64'h0, 32'd2);
        send(64'd1, 1'b0, 1'b0);
        send(64'd2, 1'b1, 1'b0);
        collect("msg");

        // Reduction through the top bit
        do_start(1'b1);
        push_const(64'h8000_0000_0000_0000, 64'h1B, 64'h36, 64'h6C, 32'd2);
        send(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        send(64'h0, 1'b1, 1'b0);
        collect("reduce");

        // Empty message closed by fin
        do_start(1'b1);
        push_const(64'h0, 64'h0, 64'h0, 64'h0, 32'd0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("empty_latency", 256'(out_valid), 256'(1));
        collect("empty");

        // Transfer together with fin: block absorbed, then DONE
        do_start(1'b1);
        push_const(64'h5, 64'h5, 64'h5, 64'h5, 32'd1);
        send(64'd5, 1'b0, 1'b1);
        chk("finxfer_done", 256'(out_valid), 256'(1));
        collect("finxfer");

        // Backpressure in DONE with start pulses that must be ignored
        do_start(1'b1);
        push_const(64'h3, 64'h0, 64'h6, 64'hA, 32'd2);
        send(64'd1, 1'b0, 1'b0);
        send(64'd2, 1'b1, 1'b0);
        held = checksum_out;
        for (int c = 0; c < 5; c++) begin
            start = c[0];
            tick();
            chk("bp_out_valid", 256'(out_valid), 256'(1));
            chk("bp_stable", checksum_out, held);
            chk("bp_in_ready", 256'(in_ready), 256'(0));
        end
        start = 1'b1;
        collect("bp");
        start = 1'b0;
        tick();
        chk("bp_start_ignored", 256'(in_ready), 256'(0));

        // Random message-mode stream with idle gaps, scored against the model
        do_start(1'b0);
        m_start(1'b0);
        for (int b = 0; b < 8; b++) begin
            rb = {$urandom(), $urandom()};
            if (b % 3 == 1) tick();
            m_absorb(rb);
            send(rb, (b == 7) ? 1'b1 : 1'b0, 1'b0);
        end
        m_push();
        collect("rand");

        // Reset in the middle of a message
        do_start(1'b1);
        send(64'd7, 1'b0, 1'b0);
        send(64'd9, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_checksum", checksum_out, 256'(0));
        chk("midrst_blk_cnt", 256'(blk_cnt), 256'(0));
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_in_ready", 256'(in_ready), 256'(0));

        // Counter saturation on the narrow-counter instance
        do_start(1'b1);
        m_start(1'b1);
        for (int b = 0; b < 5; b++) begin
            m_absorb(64'(b + 11));
            send(64'(b + 11), (b == 4) ? 1'b1 : 1'b0, 1'b0);
        end
        m_push();
        chk("sat_blk_cnt", 256'(s_blk_cnt), 256'(3));
        chk("sat_cnt_ovf", 256'(s_cnt_ovf), 256'(1));
        chk("sat_wide_ovf", 256'(cnt_ovf), 256'(0));
        collect("sat");

        // A new start clears the sticky flag
        do_start(1'b1);
        chk("sat_clear_ovf", 256'(s_cnt_ovf), 256'(0));
        chk("sat_clear_cnt", 256'(s_blk_cnt), 256'(0));
        fin = 1'b1;
        tick();
        fin = 1'b0;
        push_const(64'h0, 64'h0, 64'h0, 64'h0, 32'd0);
        collect("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
